pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It decides each cycle whether PC and IF/ID advance, hold or flush, and whether ID/EX takes a bubble. It covers load-use hazards, taken branches/jumps with a configurable flush length, and an external halt. It replaces the per-signal hazard wiring around the ID stage and adds saturating event counters for debug.

---
 rtl/pipe_stall_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Decides each cycle whether
// PC and IF/ID advance, hold or flush, and whether ID/EX takes a bubble.
// Handles load-use hazards, taken branches (multi-cycle IF/ID flush) and an
// external halt, with saturating stall/flush event counters for debug.
module pipe_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned FcntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FcntW-1:0] FcntLoad = FcntW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StHalt    = 2'd2,
    StIllegal = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic pc_w, ifid_w, flush_w, bubble_w;
  logic stall_ev;
  state_e branch_next;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    lu = ex_memread & (ex_rt != 5'd0) &
         ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

  // Next-state, flush countdown and raw pipeline controls.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_w        = 1'b1;
    ifid_w      = 1'b1;
    flush_w     = 1'b0;
    bubble_w    = 1'b0;
    stall_ev    = 1'b0;
    // With a single flush cycle the branch cycle itself is the whole flush.
    branch_next = (FLUSH_CYCLES > 1) ? StFlush : StRun;

    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          flush_w  = 1'b1;
          bubble_w = 1'b1;
          fcnt_d   = FcntLoad;
          state_d  = branch_next;
        end else if (lu) begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          bubble_w = 1'b1;
          stall_ev = 1'b1;
        end else if (halt_req) begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          bubble_w = 1'b1;
          stall_ev = 1'b1;
          state_d  = StHalt;
        end
      end
      StFlush: begin
        // ID instruction is being discarded, so lu and halt_req are ignored.
        flush_w  = 1'b1;
        bubble_w = 1'b1;
        if (branch_taken) begin
          fcnt_d  = FcntLoad;
          state_d = branch_next;
        end else if (fcnt_q <= FcntW'(1)) begin
          fcnt_d  = '0;
          state_d = StRun;
        end else begin
          fcnt_d = fcnt_q - FcntW'(1);
        end
      end
      StHalt: begin
        if (branch_taken) begin
          // A branch already in EX at halt entry still redirects the front end.
          flush_w  = 1'b1;
          bubble_w = 1'b1;
          fcnt_d   = FcntLoad;
          state_d  = branch_next;
        end else begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          bubble_w = 1'b1;
          // The exit cycle shows HALT outputs but is not counted as a stall.
          stall_ev = halt_req;
          if (!halt_req) begin
            state_d = StRun;
          end
        end
      end
      default: begin
        pc_w     = 1'b0;
        ifid_w   = 1'b0;
        bubble_w = 1'b1;
        fcnt_d   = '0;
        state_d  = StRun;
      end
    endcase
  end

  // Saturating event counters; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_w && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // State, flush countdown and counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StRun;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces a safe frozen pipeline immediately, independent of the clock.
  always_comb begin
    pc_write    = RST & pc_w;
    ifid_write  = RST & ifid_w;
    ifid_flush  = RST & flush_w;
    idex_bubble = ~RST | bubble_w;
    halted      = RST & (state_q == StHalt);
    state       = state_q;
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// random stimulus, all compared against a behavioural model of the rules.
module tb_pipe_stall_ctrl;

  localparam int unsigned FC = 2;
  localparam int unsigned CW = 3;
  localparam int CntMax = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic          branch_taken = 1'b0, halt_req = 1'b0, clr_cnt = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, halted;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining flush cycles after the current one, halt flag, counters.
  int m_flush_left = 0;
  bit m_in_halt    = 1'b0;
  int m_stall      = 0;
  int m_flush      = 0;

  pipe_stall_ctrl #(
    .FLUSH_CYCLES(FC),
    .CNT_W       (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_memread  (ex_memread),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .halt_req    (halt_req),
    .clr_cnt     (clr_cnt),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .halted      (halted),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_in_halt    = 1'b0;
    m_stall      = 0;
    m_flush      = 0;
  endtask

  // One clock cycle: drive inputs mid-cycle, compare, advance the model.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert, input logic br,
                       input logic hr, input logic cc);
    bit e_pc, e_ifid, e_fl, e_bub, e_halted, hazard, stall_inc;
    int e_state;
    @(negedge CLK);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rt = ert;
    branch_taken = br; halt_req = hr; clr_cnt = cc;
    #1;
    hazard   = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    e_state  = (m_flush_left > 0) ? 1 : (m_in_halt ? 2 : 0);
    e_halted = m_in_halt && (m_flush_left == 0);
    stall_inc = 1'b0;
    if (br) begin
      e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1;
      m_flush_left = FC - 1;
      m_in_halt    = 1'b0;
    end else if (m_flush_left > 0) begin
      e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1;
      m_flush_left--;
    end else if (m_in_halt) begin
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1;
      stall_inc = hr;
      if (!hr) m_in_halt = 1'b0;
    end else if (hazard) begin
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1;
      stall_inc = 1'b1;
    end else if (hr) begin
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1;
      stall_inc = 1'b1;
      m_in_halt = 1'b1;
    end else begin
      e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0;
    end
    chk("pc_write",    32'(pc_write),    32'(e_pc));
    chk("ifid_write",  32'(ifid_write),  32'(e_ifid));
    chk("ifid_flush",  32'(ifid_flush),  32'(e_fl));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    chk("halted",      32'(halted),      32'(e_halted));
    chk("state",       32'(state),       32'(e_state));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    chk("flush_cnt",   32'(flush_cnt),   32'(m_flush));
    if (cc) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (stall_inc && m_stall < CntMax) m_stall++;
      if (e_fl && m_flush < CntMax) m_flush++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic halt_for(input int n);
    for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, release after an edge.
  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_pc_write",    32'(pc_write),    32'd0);
    chk("rst_ifid_write",  32'(ifid_write),  32'd0);
    chk("rst_ifid_flush",  32'(ifid_flush),  32'd0);
    chk("rst_idex_bubble", 32'(idex_bubble), 32'd1);
    chk("rst_halted",      32'(halted),      32'd0);
    chk("rst_state",       32'(state),       32'd0);
    chk("rst_stall_cnt",   32'(stall_cnt),   32'd0);
    chk("rst_flush_cnt",   32'(flush_cnt),   32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    logic [4:0] r_rs, r_rt, r_ert;
    logic       r_urt, r_mr, r_br, r_hr, r_cc;

    apply_reset();

    // Idle pipeline advances freely.
    idle(10);

    // Load-use hazard gives exactly one stall.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    // ex_rt of zero never hazards.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    // rt match ignored when the instruction does not read rt.
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    // rt match honoured when it does.
    drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Clear counters, then a single branch flushes for FC cycles.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd2);
    // Branch during FLUSH extends to three flush cycles.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("br2_flush_cnt", 32'(flush_cnt), 32'd5);

    // Branch and load-use together: flush wins, no stall counted.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Halt during flush is deferred until the flush ends.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    halt_for(3);
    idle(3);

    // Four-cycle halt request: four stall counts, exit cycle not counted.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    halt_for(4);
    idle(1);
    chk("halt_stall_cnt", 32'(stall_cnt), 32'd4);
    idle(1);

    // Branch already in EX while halted.
    halt_for(2);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    halt_for(2);
    idle(3);

    // Saturation of the 3-bit stall counter.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    halt_for(10);
    idle(2);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd7);

    // Reset mid-FLUSH and mid-HALT leaves no residue.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    apply_reset();
    idle(2);
    halt_for(2);
    apply_reset();
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        r_rs  = 5'($urandom_range(0, 3));
        r_rt  = 5'($urandom_range(0, 3));
        r_ert = 5'($urandom_range(0, 3));
        r_urt = 1'($urandom_range(0, 1));
        r_mr  = 1'($urandom_range(0, 1));
        r_br  = ($urandom_range(0, 7) == 0);
        r_hr  = ($urandom_range(0, 4) == 0) || (halt_req && ($urandom_range(0, 3) != 0));
        r_cc  = ($urandom_range(0, 19) == 0);
        drive(r_rs, r_rt, r_urt, r_mr, r_ert, r_br, r_hr, r_cc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
